// File: rtl/qos_pkg.sv
// Shared constants and types for the QoS egress merge stage.
// The class field sits at word bits [11:10]; the counters are 5-bit saturating.
package qos_pkg;

  localparam int DATA_W    = 12;
  localparam int NUM_CLASS = 4;
  localparam int CNT_W     = 5;
  localparam int IDX_TOTAL = 4;
  localparam int CLS_HI    = 11;
  localparam int CLS_LO    = 10;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam cnt_t CNT_MAX = '1;

  // Word popped last cycle; its FIFO dataout is valid in this cycle.
  typedef struct packed {
    logic       vld;
    logic [1:0] cls;
  } meta_t;

  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == CNT_MAX) ? c : c + cnt_t'(1);
  endfunction

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (oh[i]) r = 2'(i);
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// 4-way arbiter: combinational one-hot grant; the pointer moves past the winner when upd_en is high.
// Zero latency, no backpressure of its own. With QOS_STRICT_PRIO_EN defined, the lowest index always wins.
module rr_arbiter_4 (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] request,
  input  logic       upd_en,
  output logic [3:0] grant
);

`ifdef QOS_STRICT_PRIO_EN
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, reset, upd_en};

  always_comb begin
    grant = '0;
    for (int i = 3; i >= 0; i--)
      if (request[i]) grant = 4'(1) << i;
  end
`else
  logic [1:0] rr_ptr;
  logic [1:0] gnt_idx;
  logic [1:0] cand;

  // Walk from the farthest offset down to 0, so the offset closest to rr_ptr is applied last and wins.
  always_comb begin
    grant   = '0;
    gnt_idx = rr_ptr;
    cand    = '0;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_ptr + 2'(k);
      if (request[cand]) begin
        grant   = 4'(1) << cand;
        gnt_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rr_ptr <= '0;
    else if (upd_en && |grant)
      rr_ptr <= gnt_idx + 2'd1;
  end
`endif

endmodule

// File: rtl/qos_egress_arbiter.sv
// Merges FIFOs P0..P3 onto one registered stream. The pop-to-out_valid latency is 2 cycles. Pops stop in the cycle out_almost_full is high.
// A word already in flight still completes. Per-class and total counters are read back over req/idx. QOS_STRICT_PRIO_EN selects strict priority.
module qos_egress_arbiter
  import qos_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              active_in,
  input  logic              init,
  input  logic [3:0]        fifo_empty,
  input  logic [DATA_W-1:0] fifo_dataout0,
  input  logic [DATA_W-1:0] fifo_dataout1,
  input  logic [DATA_W-1:0] fifo_dataout2,
  input  logic [DATA_W-1:0] fifo_dataout3,
  output logic [3:0]        pop,
  input  logic              out_almost_full,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              req,
  input  logic [2:0]        idx,
  output logic              cnt_valid,
  output logic [CNT_W-1:0]  cnt_data
);

  logic [3:0] eligible;
  logic [3:0] grant;
  meta_t      inflight;
  word_t      sel_word;
  cnt_t       cnt [NUM_CLASS];
  cnt_t       cnt_total;
  cnt_t       rd_sel;

  // reset is folded in so that pop drops at the moment reset asserts.
  assign eligible = ~fifo_empty & {4{active_in & ~out_almost_full & reset}};

  rr_arbiter_4 u_arb (
    .clk     (clk),
    .reset   (reset),
    .request (eligible),
    .upd_en  (|eligible),
    .grant   (grant)
  );

  assign pop = grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight <= '0;
    end else begin
      inflight.vld <= |pop;
      inflight.cls <= oh2idx(pop);
    end
  end

  always_comb begin
    sel_word = fifo_dataout0;
    case (inflight.cls)
      2'd0: sel_word = fifo_dataout0;
      2'd1: sel_word = fifo_dataout1;
      2'd2: sel_word = fifo_dataout2;
      2'd3: sel_word = fifo_dataout3;
      default: sel_word = fifo_dataout0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= inflight.vld;
      if (inflight.vld)
        out_data <= sel_word;
    end
  end

  // Counters track the class field of the delivered word. init takes priority over an increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CLASS; i++) cnt[i] <= '0;
      cnt_total <= '0;
    end else if (init) begin
      for (int i = 0; i < NUM_CLASS; i++) cnt[i] <= '0;
      cnt_total <= '0;
    end else if (out_valid) begin
      cnt[out_data[CLS_HI:CLS_LO]] <= sat_inc(cnt[out_data[CLS_HI:CLS_LO]]);
      cnt_total                    <= sat_inc(cnt_total);
    end
  end

  always_comb begin
    rd_sel = '0;
    case (idx)
      3'd0, 3'd1, 3'd2, 3'd3: rd_sel = cnt[idx[1:0]];
      3'(IDX_TOTAL):          rd_sel = cnt_total;
      default:                rd_sel = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_valid <= 1'b0;
      cnt_data  <= '0;
    end else begin
      cnt_valid <= req;
      cnt_data  <= req ? rd_sel : '0;
    end
  end

endmodule

// File: tb/tb_qos_egress_arbiter.sv
// Directed bench for qos_egress_arbiter: behavioural FIFOs P0..P3, pop/output logs, and per-scenario tasks.
module tb_qos_egress_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        active_in;
  logic        init;
  logic [3:0]  fifo_empty;
  logic [11:0] fdo [4] = '{default: 12'h000};
  logic [3:0]  pop;
  logic        out_almost_full;
  logic [11:0] out_data;
  logic        out_valid;
  logic        req;
  logic [2:0]  idx;
  logic        cnt_valid;
  logic [4:0]  cnt_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [11:0] mem [4][64];
  int          wr_ptr [4] = '{0, 0, 0, 0};
  int          rd_ptr [4] = '{0, 0, 0, 0};

  int          pop_cyc [$];
  logic [3:0]  pop_vec [$];
  logic [11:0] obs_dat [$];
  int          obs_cyc [$];

  always #5 clk = ~clk;

  qos_egress_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .active_in       (active_in),
    .init            (init),
    .fifo_empty      (fifo_empty),
    .fifo_dataout0   (fdo[0]),
    .fifo_dataout1   (fdo[1]),
    .fifo_dataout2   (fdo[2]),
    .fifo_dataout3   (fdo[3]),
    .pop             (pop),
    .out_almost_full (out_almost_full),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .req             (req),
    .idx             (idx),
    .cnt_valid       (cnt_valid),
    .cnt_data        (cnt_data)
  );

  always_comb begin
    fifo_empty = '0;
    for (int i = 0; i < 4; i++) fifo_empty[i] = (rd_ptr[i] == wr_ptr[i]);
  end

  // FIFO read data appears the cycle after the pop; cyc names the cycle the pop was high in.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (pop[i] && !fifo_empty[i]) begin
        fdo[i]    <= mem[i][rd_ptr[i] % 64];
        rd_ptr[i] <= rd_ptr[i] + 1;
      end
    if (|pop) begin
      pop_cyc.push_back(cyc);
      pop_vec.push_back(pop);
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (out_valid) begin
      obs_dat.push_back(out_data);
      obs_cyc.push_back(cyc);
    end
  end

  task automatic push(input int c, input logic [11:0] d);
    mem[c][wr_ptr[c] % 64] = d;
    wr_ptr[c] = wr_ptr[c] + 1;
  endtask

  task automatic do_read(input logic [2:0] k, output logic v, output logic [4:0] d);
    idx = k;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    v = cnt_valid;
    d = cnt_data;
  endtask

  task automatic wait_obs(input int n, input int budget, input string name);
    for (int t = 0; t < budget && obs_dat.size() < n; t++) @(negedge clk);
    total++;
    if (obs_dat.size() < n) begin
      bad++;
      $display("FAIL %s_timeout: got %0d words want %0d", name, obs_dat.size(), n);
    end
  endtask

  task automatic test_reset();
    logic v;
    logic [4:0] d;
    reset = 1'b0; active_in = 1'b1; init = 1'b0; out_almost_full = 1'b0; req = 1'b0; idx = '0;
    repeat (3) @(negedge clk);
    total++; if (pop !== 4'b0000)  begin bad++; $display("FAIL rst_pop: got %b want 0000", pop); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 12'h000) begin bad++; $display("FAIL rst_out_data: got %h want 000", out_data); end
    total++; if (cnt_valid !== 1'b0) begin bad++; $display("FAIL rst_cnt_valid: got %b want 0", cnt_valid); end
    total++; if (cnt_data !== 5'd0) begin bad++; $display("FAIL rst_cnt_data: got %0d want 0", cnt_data); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (pop !== 4'b0000 || out_valid !== 1'b0) begin bad++; $display("FAIL idle_empty: got pop=%b ov=%b want 0000/0", pop, out_valid); end
    for (int k = 0; k < 5; k++) begin
      do_read(3'(k), v, d);
      total++;
      if (v !== 1'b1 || d !== 5'd0) begin bad++; $display("FAIL rst_read%0d: got v=%b d=%0d want v=1 d=0", k, v, d); end
    end
    @(negedge clk);
    total++; if (cnt_valid !== 1'b0 || cnt_data !== 5'd0) begin bad++; $display("FAIL no_req: got v=%b d=%0d want 0/0", cnt_valid, cnt_data); end
  endtask

  task automatic test_round_robin();
    logic [11:0] exp_d [4] = '{12'h0FF, 12'h15A, 12'h404, 12'h55A};
    int base  = obs_dat.size();
    int pbase = pop_cyc.size();
    int first;
    @(negedge clk);
    push(0, 12'h0FF); push(0, 12'h404);
    push(1, 12'h15A); push(1, 12'h55A);
    wait_obs(base + 4, 20, "rr");
    repeat (2) @(negedge clk);
    first = (pop_cyc.size() > pbase) ? pop_cyc[pbase] : -100;
    total++;
    if (pop_cyc.size() - pbase != 4) begin bad++; $display("FAIL rr_pops: got %0d want 4", pop_cyc.size() - pbase); end
    total++;
    if (pop_vec.size() <= pbase || pop_vec[pbase] !== 4'b0001) begin bad++; $display("FAIL rr_first_pop: got %b want 0001", (pop_vec.size() > pbase) ? pop_vec[pbase] : 4'bx); end
    for (int j = 0; j < 4; j++) begin
      if (obs_dat.size() > base + j) begin
        total++;
        if (obs_dat[base + j] !== exp_d[j]) begin bad++; $display("FAIL rr_data%0d: got %h want %h", j, obs_dat[base + j], exp_d[j]); end
        total++;
        if (obs_cyc[base + j] != first + 2 + j) begin bad++; $display("FAIL rr_cycle%0d: got %0d want %0d", j, obs_cyc[base + j], first + 2 + j); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] exp_d [8] = '{12'h801, 12'hC01, 12'h001, 12'h401, 12'h802, 12'hC02, 12'h002, 12'h402};
    int          exp_o [8] = '{2, 6, 7, 8, 9, 10, 11, 12};
    int base  = obs_dat.size();
    int pbase = pop_cyc.size();
    int c;
    int held;
    @(negedge clk);
    push(0, 12'h001); push(0, 12'h002);
    push(1, 12'h401); push(1, 12'h402);
    push(2, 12'h801); push(2, 12'h802);
    push(3, 12'hC01); push(3, 12'hC02);
    @(negedge clk);
    out_almost_full = 1'b1;
    repeat (3) @(negedge clk);
    out_almost_full = 1'b0;
    wait_obs(base + 8, 40, "bp");
    repeat (2) @(negedge clk);
    c = (pop_cyc.size() > pbase) ? pop_cyc[pbase] : -100;
    total++;
    if (pop_vec.size() <= pbase || pop_vec[pbase] !== 4'b0100) begin bad++; $display("FAIL bp_first_pop: got %b want 0100", (pop_vec.size() > pbase) ? pop_vec[pbase] : 4'bx); end
    held = 0;
    for (int j = pbase; j < pop_cyc.size(); j++)
      if (pop_cyc[j] >= c + 1 && pop_cyc[j] <= c + 3) held++;
    total++;
    if (held != 0) begin bad++; $display("FAIL bp_hold: got %0d pops want 0", held); end
    total++;
    if (pop_vec.size() <= pbase + 1 || pop_vec[pbase + 1] !== 4'b1000 || pop_cyc[pbase + 1] != c + 4) begin
      bad++; $display("FAIL bp_resume: got %b want 1000 at cycle offset 4", (pop_vec.size() > pbase + 1) ? pop_vec[pbase + 1] : 4'bx);
    end
    for (int j = 0; j < 8; j++) begin
      if (obs_dat.size() > base + j) begin
        total++;
        if (obs_dat[base + j] !== exp_d[j] || obs_cyc[base + j] != c + exp_o[j]) begin
          bad++; $display("FAIL bp_word%0d: got %h@%0d want %h@%0d", j, obs_dat[base + j], obs_cyc[base + j] - c, exp_d[j], exp_o[j]);
        end
      end
    end
  endtask

  task automatic test_strict();
    logic [11:0] exp_d [6] = '{12'h011, 12'h012, 12'h013, 12'hC11, 12'hC12, 12'hC13};
    int base = obs_dat.size();
    @(negedge clk);
    push(3, 12'hC11); push(3, 12'hC12); push(3, 12'hC13);
    push(0, 12'h011); push(0, 12'h012); push(0, 12'h013);
    wait_obs(base + 6, 30, "strict");
    for (int j = 0; j < 6; j++) begin
      if (obs_dat.size() > base + j) begin
        total++;
        if (obs_dat[base + j] !== exp_d[j]) begin bad++; $display("FAIL strict_word%0d: got %h want %h", j, obs_dat[base + j], exp_d[j]); end
      end
    end
  endtask

  task automatic test_saturation();
    logic v;
    logic [4:0] d;
    logic [2:0] ridx [5] = '{3'd2, 3'd4, 3'd0, 3'd6, 3'd3};
    logic [4:0] rexp [5] = '{5'd31, 5'd31, 5'd0, 5'd0, 5'd0};
    int base;
    @(negedge clk); init = 1'b1;
    @(negedge clk); init = 1'b0;
    base = obs_dat.size();
    for (int j = 0; j < 35; j++) push(2, 12'h800 + 12'(j));
    wait_obs(base + 35, 120, "sat");
    repeat (3) @(negedge clk);
    total++;
    if (obs_dat.size() - base != 35) begin bad++; $display("FAIL sat_words: got %0d want 35", obs_dat.size() - base); end
    for (int k = 0; k < 5; k++) begin
      do_read(ridx[k], v, d);
      total++;
      if (v !== 1'b1 || d !== rexp[k]) begin bad++; $display("FAIL sat_read_idx%0d: got v=%b d=%0d want v=1 d=%0d", ridx[k], v, d, rexp[k]); end
    end
  endtask

  task automatic test_init_read();
    logic v;
    logic [4:0] d;
    int base;
    @(negedge clk); init = 1'b1;
    @(negedge clk); init = 1'b0;
    base = obs_dat.size();
    push(2, 12'h8A0); push(2, 12'h8A1); push(2, 12'h8A2);
    wait_obs(base + 3, 20, "init");
    repeat (3) @(negedge clk);
    init = 1'b1; idx = 3'd2; req = 1'b1;
    @(negedge clk);
    init = 1'b0; req = 1'b0;
    total++;
    if (cnt_valid !== 1'b1 || cnt_data !== 5'd3) begin bad++; $display("FAIL init_same_cycle: got v=%b d=%0d want v=1 d=3", cnt_valid, cnt_data); end
    do_read(3'd2, v, d);
    total++;
    if (v !== 1'b1 || d !== 5'd0) begin bad++; $display("FAIL init_after: got v=%b d=%0d want v=1 d=0", v, d); end
    do_read(3'd4, v, d);
    total++;
    if (v !== 1'b1 || d !== 5'd0) begin bad++; $display("FAIL init_total: got v=%b d=%0d want v=1 d=0", v, d); end
  endtask

  task automatic test_mid_reset();
    int base = obs_dat.size();
    @(negedge clk);
    for (int j = 0; j < 8; j++) push(1, 12'h4E0 + 12'(j));
    wait_obs(base + 1, 10, "midrst");
    #2 reset = 1'b0;
    #1;
    total++; if (pop !== 4'b0000) begin bad++; $display("FAIL midrst_pop: got %b want 0000", pop); end
    total++; if (out_valid !== 1'b0 || out_data !== 12'h000) begin bad++; $display("FAIL midrst_out: got ov=%b d=%h want 0/000", out_valid, out_data); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
  endtask

  initial begin
    test_reset();
`ifdef QOS_STRICT_PRIO_EN
    test_strict();
`else
    test_round_robin();
    test_backpressure();
`endif
    test_saturation();
    test_init_read();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
